// File: rtl/sub_sched_pkg.sv
// Shared defaults, id-width helper and output-register state/record types for sub_rr_scheduler.
package sub_sched_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_BITS  = 16;
  localparam int DEF_CNT_W = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int DEF_ID_W = clog2(DEF_N_REQ);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Response record layout {id, ovf, diff}; the top re-declares it at its own widths in this order.
  typedef struct packed {
    logic [DEF_ID_W-1:0] id;
    logic                ovf;
    logic [DEF_BITS-1:0] diff;
  } rsp_rec_t;

endpackage

// File: rtl/sub_rr_scheduler_if.sv
// Requester and response bundle of the shared subtractor scheduler.
interface sub_rr_scheduler_if
  import sub_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int BITS  = DEF_BITS,
  parameter int ID_W  = clog2(N_REQ),
  parameter int CNT_W = DEF_CNT_W
);
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*BITS-1:0] req_in1;
  logic [N_REQ*BITS-1:0] req_in2;
  logic [N_REQ-1:0]      req_ready;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [BITS-1:0]       rsp_diff;
  logic                  rsp_ovf;
  logic                  rsp_ready;
  logic [CNT_W-1:0]      op_count;

  modport master (
    output req_valid, req_in1, req_in2, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_diff, rsp_ovf, op_count
  );

  modport slave (
    input  req_valid, req_in1, req_in2, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_diff, rsp_ovf, op_count
  );
endinterface

// File: rtl/sub_rr_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first valid index at or after ptr_i, wrapping; no grant unless free_i.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]  ptr_i,
  input  logic             free_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  gnt_idx_o,
  output logic             gnt_vld_o
);
  logic [ID_W-1:0] j;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    j         = '0;
    // Scan farthest-first so the candidate nearest ptr_i overwrites the rest.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = ID_W'((int'(ptr_i) + k) % N_REQ);
      if (free_i && valid_i[j]) begin
        gnt_o     = '0;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = j;
        gnt_vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sub_rr_scheduler_subtractor.sv
// Two's-complement subtractor, purely combinational; diff wraps modulo 2^W.
module subtractor #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o
);
  assign diff_o = a_i + (~b_i + W'(1));
endmodule

// File: rtl/sub_rr_scheduler.sv
// Round-robin time-sharing of one subtractor among N_REQ requesters; one registered result per cycle,
// one-cycle accept-to-valid latency, grants withheld while the output register is stalled.
module sub_rr_scheduler
  import sub_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int BITS  = DEF_BITS,
  parameter int ID_W  = clog2(N_REQ),
  parameter int CNT_W = DEF_CNT_W
) (
  input logic               clk,
  input logic               rst,
  sub_rr_scheduler_if.slave bus
);
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            ovf;
    logic [BITS-1:0] diff;
  } rsp_t;

  out_state_e       state_q, state_d;
  rsp_t             rsp_q, rsp_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             free, accept, handoff, ovf;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic [BITS-1:0]  op_a, op_b, diff;

  assign handoff = (state_q == FULL) && bus.rsp_ready;
  // Reset gates the slot so nothing is granted during the reset cycle.
  assign free    = !rst && ((state_q == EMPTY) || bus.rsp_ready);

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .valid_i   (bus.req_valid),
    .ptr_i     (rr_ptr_q),
    .free_i    (free),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (accept)
  );

  assign op_a = bus.req_in1[int'(gnt_idx) * BITS +: BITS];
  assign op_b = bus.req_in2[int'(gnt_idx) * BITS +: BITS];

  subtractor #(
    .W (BITS)
  ) u_sub (
    .a_i    (op_a),
    .b_i    (op_b),
    .diff_o (diff)
  );

  assign ovf = (op_a[BITS-1] != op_b[BITS-1]) && (diff[BITS-1] != op_a[BITS-1]);

  always_comb begin
    state_d  = state_q;
    rsp_d    = rsp_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    if (handoff) begin
      state_d = EMPTY;
      cnt_d   = cnt_q + CNT_W'(1);
    end
    if (accept) begin
      state_d  = FULL;
      rsp_d    = '{id: gnt_idx, ovf: ovf, diff: diff};
      rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      rsp_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rsp_q    <= rsp_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = (state_q == FULL);
  assign bus.rsp_id    = rsp_q.id;
  assign bus.rsp_diff  = rsp_q.diff;
  assign bus.rsp_ovf   = rsp_q.ovf;
  assign bus.op_count  = cnt_q;
endmodule

// File: doc/sub_rr_scheduler.md
Name: sub_rr_scheduler

Overview:
- Time-shares one two's-complement subtractor between N_REQ requesters, such as the CWT scale/shift lanes producing sample differences.
- Uses round-robin arbitration and a per-requester valid/ready handshake.
- Registers one result per cycle, tagged with the requester id and a signed-overflow flag.
- Sits between the lane controllers and the downstream accumulator; the downstream side can apply backpressure.

Parameters:
- BITS, 16, operand and result width (two's complement).
- N_REQ, 4, number of requesters (at least 2).
- ID_W, 2, requester id width; must equal clog2(N_REQ).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_in1  in  N_REQ*BITS  minuends; requester i occupies bits [i*BITS +: BITS].
- req_in2  in  N_REQ*BITS  subtrahends; same packing as req_in1.
- req_ready  out  N_REQ  one-hot accept strobe; at most one bit is high per cycle.
- rsp_valid  out  1  a result is held in the output register.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_diff  out  BITS  in1 - in2, modulo 2^BITS.
- rsp_ovf  out  1  signed overflow of that subtraction.
- rsp_ready  in  1  downstream accepts the result.
- op_count  out  CNT_W  number of results handed off since reset; wraps.

Behaviour:
- Reset (rst=1 at a clk edge):
  - rsp_valid=0, rsp_id=0, rsp_diff=0, rsp_ovf=0, op_count=0, rr_ptr=0.
  - req_ready is 0 during the reset cycle.
  - Any held or in-flight result is discarded. No handshake completes in the reset cycle.
- Output register states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- Slot free (combinational): free = EMPTY, or (FULL and rsp_ready).
- Grant (combinational):
  - If free and any req_valid is high, grant the first valid index at or after rr_ptr, searching upward and wrapping from N_REQ-1 to 0.
  - req_ready[g]=1 for the granted index only. All other bits are 0.
  - If not free, req_ready=0.
- Accept:
  - Occurs when req_valid[g] and req_ready[g] are both high.
  - At the next edge the output register loads id=g, diff=in1-in2 and ovf. The state is FULL and rr_ptr becomes (g+1) mod N_REQ.
  - Latency is one cycle: rsp_valid rises on the edge after the accept cycle.
- Handoff:
  - Occurs when rsp_valid and rsp_ready are both high. op_count increments by 1, wrapping to 0.
  - If an accept happens in the same cycle, the register reloads and stays FULL. Sustained throughput is one result per cycle.
  - Otherwise the state goes to EMPTY. rsp_id, rsp_diff and rsp_ovf keep their stale values.
- Stall: while FULL and rsp_ready=0, all outputs hold and req_ready=0.
- Requester obligations:
  - Hold operands stable while valid and not ready.
  - Drop req_valid only after the accept cycle.
  - The block never samples operands outside the accept cycle.
- No request: rr_ptr is unchanged.
- Fairness: a continuously valid requester is granted within N_REQ accepts.
- Arithmetic:
  - diff = in1 + (~in2 + 1), truncated to BITS.
  - ovf = (in1[MSB] != in2[MSB]) and (diff[MSB] != in1[MSB]).
  - Both are computed in the accept cycle and registered.
- Corner values:
  - in1=0x8000, in2=0x0001 gives diff=0x7FFF, ovf=1.
  - in2=0x8000, in1=0x0000 gives diff=0x8000, ovf=1.

Decomposition:
- Shared package sub_sched_pkg holds:
  - default N_REQ, BITS and CNT_W;
  - the function clog2 used to derive ID_W;
  - the response-record field ordering {id, ovf, diff}.
- Sub-modules:
  - One instance of the team's existing subtractor module computes diff from the muxed operands.
  - One small natural sub-module, rr_arbiter, takes valid, rr_ptr and free and produces a one-hot grant and its index.
- The top level holds the operand mux, overflow logic, output register, rr_ptr and op_count.

Test Plan:
1. Reset with all four requesters valid, then release with rsp_ready=1.
   - Grants go 0,1,2,3,0 on consecutive cycles; each rsp_id follows its grant by one cycle; op_count increments by 1 per handoff.
2. Only requester 2 valid with in1=0x0005, in2=0x0009.
   - One cycle after the accept: rsp_valid=1, rsp_id=2, rsp_diff=0xFFFC, rsp_ovf=0.
3. Overflow corners.
   - Requester 1 with in1=0x8000, in2=0x0001 gives rsp_diff=0x7FFF, rsp_ovf=1.
   - Requester 3 with in1=0x7FFF, in2=0xFFFF gives rsp_diff=0x8000, rsp_ovf=1.
4. Backpressure: rsp_ready=0 for 5 cycles while requesters 0 and 1 are valid.
   - Exactly one accept occurs, then req_ready=0 and the outputs stay constant.
   - After rsp_ready rises, the held result hands off and requester 1 is accepted in the same cycle.
5. Reset mid-operation: assert rst while FULL and stalled.
   - Next cycle: rsp_valid=0, op_count=0, and the first grant after release goes to requester 0.
6. op_count wrap with CNT_W=4.
   - 17 handoffs leave op_count=1.
